code_loader: RTL and testbench
==============================

Name: code_loader

Overview:
- Host-side loader that drives the code storage write and code-control interfaces of data_path; it replaces bench-driven stimulus in hardware.
- Accepts a byte stream from a host link (valid/ready), assembles 12-bit instruction words and writes them to consecutive code storage lines starting at 0.
- After the last word it resets the fetch index and holds code_active so data_path begins executing.

Parameters:
- DATA_WIDTH, 12, instruction word width (matches code storage write_data)
- LINE_WIDTH, 32, code storage line index width
- MAX_LINES, 256, code storage capacity; writes at index >= MAX_LINES are an overflow

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  synchronous, active-low reset
- host_start  in  1  one-cycle pulse: begin a new load (aborts any load or run)
- host_byte  in  8  stream byte
- host_valid  in  1  host_byte valid
- host_ready  out  1  loader accepts host_byte this cycle
- code_storage_write_interface_write_line  out  LINE_WIDTH  target line
- code_storage_write_interface_write_data  out  DATA_WIDTH  instruction word
- code_storage_write_interface_is_write  out  1  write strobe, one cycle per word
- code_storage_code_control_interface_reset  out  1  fetch index reset pulse
- code_storage_code_control_interface_active  out  1  execution enable
- loading  out  1  load in progress
- error  out  1  sticky overflow flag
- line_count  out  LINE_WIDTH  words written in the current or last load

Behaviour:
- Reset (reset_reset_n=0 at a clock edge): state IDLE; all outputs 0; line counter 0. Reset mid-load discards the partial word and drops active the same edge.
- Byte transfer occurs when host_valid & host_ready are both high at a clock edge.
- Word format: byte 0 -> data[7:0]. Byte 1: bits[3:0] -> data[11:8], bit 7 = last flag, bits[6:4] ignored.
- FSM states: IDLE, CLEAR, LO, HI, WR, ARM, RUN, ERR.
- IDLE: host_ready=0. On host_start, go to CLEAR.
- CLEAR (1 cycle): control reset=1, active=0, line counter<=0, error<=0, then LO.
- LO: host_ready=1, loading=1. On transfer, latch the low byte and go to HI.
- HI: host_ready=1. On transfer, latch data[11:8] and the last flag, then go to WR.
- WR (1 cycle): host_ready=0.
  - If counter < MAX_LINES: is_write=1, write_line=counter, write_data=assembled word; counter += 1; go to ARM if last, else LO.
  - If counter >= MAX_LINES: no write; go to ERR.
- Latency: is_write is high in the cycle after the HI byte transfer.
- write_line and write_data hold their last values outside WR; only is_write qualifies them.
- ARM (1 cycle): control reset=1, then RUN.
- RUN: active=1, loading=0, host_ready=0. Stays in RUN until host_start or reset.
- ERR: error=1, active=0, loading=0. Stays in ERR until host_start.
- host_start in any non-IDLE state goes to CLEAR on the next edge. host_start has priority over a simultaneous byte transfer; that byte is dropped.
- line_count mirrors the counter and is stable after the load.
- The counter never wraps. MAX_LINES words is legal; word MAX_LINES+1 triggers ERR.
- host_valid is ignored while host_ready=0. The host must hold host_byte stable until the transfer.

Decomposition:
- Shared package code_loader_pkg:
  - state enum
  - LAST_BIT=7 and DATA_HI_LSB=8 constants
  - DATA_WIDTH/LINE_WIDTH defaults, also used by code storage
- One sub-module code_word_assembler: LO/HI byte latching plus last flag, with an assembled-word-valid output.
- The FSM and counter stay in the top module.

Test Plan:
- Basic load: start, then bytes 0x34,0x02 / 0x78,0x85 -> is_write at line 0 data 0x234, line 1 data 0x578; reset pulse in ARM; active=1; line_count=2.
- Backpressure and gaps: host_valid toggled 1/0 each cycle over 3 words -> exactly 3 is_write pulses with correct data; host_ready=0 during WR/ARM/RUN.
- Overflow (MAX_LINES=4): 5 words, last flag on word 5 -> 4 writes at lines 0..3; no 5th write; error=1; active=0; a later host_start clears error.
- Restart mid-word: start, byte 0x11, then host_start together with a valid byte -> CLEAR; byte dropped; next pair 0xAA,0x83 -> line 0 data 0x3AA.
- Reset during RUN: after a load, reset_reset_n=0 for one edge -> active=0, all outputs 0, state IDLE; bytes ignored until host_start.
- Rerun: host_start while in RUN -> active drops the next edge, control reset pulses, reload writes from line 0.

Source files
------------

// File: rtl/code_loader_pkg.sv
// Shared types and constants for the host code loader.
// Widths here also size the code storage write port.
package code_loader_pkg;

  localparam int DATA_WIDTH_DEF = 12;
  localparam int LINE_WIDTH_DEF = 32;
  localparam int MAX_LINES_DEF  = 256;
  localparam int LAST_BIT       = 7;
  localparam int DATA_HI_LSB    = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LO,
    S_HI,
    S_WR,
    S_ARM,
    S_RUN,
    S_ERR
  } state_e;

endpackage

// File: rtl/code_word_assembler.sv
// Latches the low and high bytes of an instruction word plus its last flag.
// word_valid is high for the cycle after the high byte is taken.
module code_word_assembler
  import code_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lo_en,
  input  logic                  hi_en,
  input  logic [7:0]            byte_in,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  last,
  output logic                  word_valid
);

  localparam int HI_W = DATA_WIDTH - DATA_HI_LSB;

  logic [7:0]      lo_q, lo_d;
  logic [HI_W-1:0] hi_q, hi_d;
  logic            last_q, last_d;
  logic            valid_q, valid_d;

  always_comb begin
    lo_d    = lo_q;
    hi_d    = hi_q;
    last_d  = last_q;
    valid_d = 1'b0;
    if (lo_en) lo_d = byte_in;
    if (hi_en) begin
      hi_d    = byte_in[HI_W-1:0];
      last_d  = byte_in[LAST_BIT];
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lo_q    <= '0;
      hi_q    <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign word       = {hi_q, lo_q};
  assign last       = last_q;
  assign word_valid = valid_q;

endmodule

// File: rtl/code_loader.sv
// Streams host bytes into code storage as 12-bit words, then arms
// the fetch index and enables execution.
module code_loader
  import code_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LINE_WIDTH = LINE_WIDTH_DEF,
  parameter int MAX_LINES  = MAX_LINES_DEF
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic                  host_start,
  input  logic [7:0]            host_byte,
  input  logic                  host_valid,
  output logic                  host_ready,
  output logic [LINE_WIDTH-1:0] code_storage_write_interface_write_line,
  output logic [DATA_WIDTH-1:0] code_storage_write_interface_write_data,
  output logic                  code_storage_write_interface_is_write,
  output logic                  code_storage_code_control_interface_reset,
  output logic                  code_storage_code_control_interface_active,
  output logic                  loading,
  output logic                  error,
  output logic [LINE_WIDTH-1:0] line_count
);

  state_e                state_q, state_d;
  logic [LINE_WIDTH-1:0] cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [LINE_WIDTH-1:0] wl_q, wl_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;

  logic [DATA_WIDTH-1:0] word;
  logic                  word_last;
  logic                  word_valid;
  logic                  is_write;
  logic                  lo_en, hi_en;

  // A start request wins over a byte offered in the same cycle.
  assign lo_en = (state_q == S_LO) & host_valid & ~host_start;
  assign hi_en = (state_q == S_HI) & host_valid & ~host_start;

  code_word_assembler #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_asm (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .lo_en     (lo_en),
    .hi_en     (hi_en),
    .byte_in   (host_byte),
    .word      (word),
    .last      (word_last),
    .word_valid(word_valid)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    wl_d       = wl_q;
    wd_d       = wd_q;
    host_ready = 1'b0;
    is_write   = 1'b0;
    loading    = 1'b0;
    code_storage_code_control_interface_reset  = 1'b0;
    code_storage_code_control_interface_active = 1'b0;
    unique case (state_q)
      S_IDLE: ;
      S_CLEAR: begin
        code_storage_code_control_interface_reset = 1'b1;
        loading = 1'b1;
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = S_LO;
      end
      S_LO: begin
        host_ready = 1'b1;
        loading    = 1'b1;
        if (host_valid) state_d = S_HI;
      end
      S_HI: begin
        host_ready = 1'b1;
        loading    = 1'b1;
        if (host_valid) state_d = S_WR;
      end
      S_WR: begin
        loading = 1'b1;
        if (word_valid && cnt_q < LINE_WIDTH'(MAX_LINES)) begin
          is_write = 1'b1;
          wl_d     = cnt_q;
          wd_d     = word;
          cnt_d    = cnt_q + LINE_WIDTH'(1);
          state_d  = word_last ? S_ARM : S_LO;
        end else begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end
      end
      S_ARM: begin
        code_storage_code_control_interface_reset = 1'b1;
        loading = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: code_storage_code_control_interface_active = 1'b1;
      S_ERR: ;
      default: state_d = S_IDLE;
    endcase
    if (host_start) state_d = S_CLEAR;
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      wl_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      wl_q    <= wl_d;
      wd_q    <= wd_d;
    end
  end

  assign code_storage_write_interface_is_write   = is_write;
  assign code_storage_write_interface_write_line = is_write ? cnt_q : wl_q;
  assign code_storage_write_interface_write_data = is_write ? word : wd_q;
  assign error      = err_q;
  assign line_count = cnt_q;

endmodule

// File: tb/tb_code_loader.sv
// Directed plus randomized bench for code_loader with a small capacity
// so the overflow path is reachable.
module tb_code_loader;

  localparam int MAXL = 4;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic        host_start;
  logic [7:0]  host_byte;
  logic        host_valid;
  logic        host_ready;
  logic [31:0] write_line;
  logic [11:0] write_data;
  logic        is_write;
  logic        ctl_reset;
  logic        active;
  logic        loading;
  logic        error;
  logic [31:0] line_count;

  int errors = 0;
  int checks = 0;
  int rst_pulses = 0;
  int viol = 0;

  logic [43:0] got[$];
  logic [11:0] wq[$];
  bit          lq[$];

  always #5 clk_clk = ~clk_clk;

  code_loader #(
    .DATA_WIDTH(12),
    .LINE_WIDTH(32),
    .MAX_LINES (MAXL)
  ) dut (
    .clk_clk                                   (clk_clk),
    .reset_reset_n                             (reset_reset_n),
    .host_start                                (host_start),
    .host_byte                                 (host_byte),
    .host_valid                                (host_valid),
    .host_ready                                (host_ready),
    .code_storage_write_interface_write_line   (write_line),
    .code_storage_write_interface_write_data   (write_data),
    .code_storage_write_interface_is_write     (is_write),
    .code_storage_code_control_interface_reset (ctl_reset),
    .code_storage_code_control_interface_active(active),
    .loading                                   (loading),
    .error                                     (error),
    .line_count                                (line_count)
  );

  always @(negedge clk_clk) begin
    if (is_write === 1'b1) got.push_back({write_line, write_data});
    if (ctl_reset === 1'b1) rst_pulses <= rst_pulses + 1;
    if ((is_write === 1'b1 || active === 1'b1) && host_ready !== 1'b0)
      viol <= viol + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic pulse_start();
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    n = 0;
    host_byte  = b;
    host_valid = 1'b1;
    while (host_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("byte_timeout", 32'(n), 0);
    else tick();
    host_valid = 1'b0;
    host_byte  = 8'($urandom);
    if (gaps) repeat ($urandom_range(0, 2)) tick();
    else if ($urandom_range(0, 1) == 1) tick();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(host_ready), 0);
    chk({tag, "_iswr"}, 32'(is_write), 0);
    chk({tag, "_line"}, write_line, 0);
    chk({tag, "_data"}, 32'(write_data), 0);
    chk({tag, "_ctlrst"}, 32'(ctl_reset), 0);
    chk({tag, "_active"}, 32'(active), 0);
    chk({tag, "_loading"}, 32'(loading), 0);
    chk({tag, "_error"}, 32'(error), 0);
    chk({tag, "_count"}, line_count, 0);
  endtask

  task automatic load_and_check(input string tag, input bit gaps);
    int n, nw, k, p0;
    bit ovf;
    got.delete();
    p0 = rst_pulses;
    pulse_start();
    chk({tag, "_clr_rst"}, 32'(ctl_reset), 1);
    chk({tag, "_clr_act"}, 32'(active), 0);
    tick();
    chk({tag, "_lo_loading"}, 32'(loading), 1);
    chk({tag, "_lo_ready"}, 32'(host_ready), 1);
    chk({tag, "_lo_err"}, 32'(error), 0);
    foreach (wq[i]) begin
      send_byte(wq[i][7:0], gaps);
      send_byte({lq[i], 3'($urandom), wq[i][11:8]}, gaps);
    end
    k = 0;
    while (!(active === 1'b1 || error === 1'b1) && k < 20) begin
      tick();
      k++;
    end
    tick();
    n   = wq.size();
    ovf = (n > MAXL);
    nw  = ovf ? MAXL : n;
    chk({tag, "_nwrites"}, 32'(got.size()), 32'(nw));
    for (int i = 0; i < nw && i < got.size(); i++) begin
      chk({tag, "_wline"}, got[i][43:12], 32'(i));
      chk({tag, "_wdata"}, 32'(got[i][11:0]), 32'(wq[i]));
    end
    chk({tag, "_error"}, 32'(error), 32'(ovf));
    chk({tag, "_active"}, 32'(active), 32'(!ovf));
    chk({tag, "_loading"}, 32'(loading), 0);
    chk({tag, "_ready"}, 32'(host_ready), 0);
    chk({tag, "_count"}, line_count, 32'(nw));
    chk({tag, "_rstpulses"}, 32'(rst_pulses - p0), ovf ? 1 : 2);
    chk({tag, "_readyviol"}, 32'(viol), 0);
  endtask

  task automatic rand_words(input int n);
    wq.delete();
    lq.delete();
    for (int i = 0; i < n; i++) begin
      wq.push_back(12'($urandom));
      lq.push_back(i == n - 1);
    end
  endtask

  initial begin
    int k;
    reset_reset_n = 1'b0;
    host_start    = 1'b0;
    host_byte     = 8'h00;
    host_valid    = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    reset_reset_n = 1'b1;
    tick();

    wq = '{12'h234, 12'h578};
    lq = '{1'b0, 1'b1};
    load_and_check("basic", 1'b0);

    for (int t = 0; t < 3; t++) begin
      rand_words(3);
      load_and_check("gaps", 1'b1);
    end

    rand_words(MAXL);
    load_and_check("full", 1'b1);

    rand_words(MAXL + 1);
    load_and_check("overflow", 1'b0);
    tick();
    chk("overflow_hold_err", 32'(error), 1);

    rand_words(2);
    load_and_check("after_ovf", 1'b0);

    got.delete();
    pulse_start();
    tick();
    send_byte(8'h11, 1'b0);
    host_start = 1'b1;
    host_valid = 1'b1;
    host_byte  = 8'h55;
    tick();
    host_start = 1'b0;
    host_valid = 1'b0;
    chk("restart_clr", 32'(ctl_reset), 1);
    tick();
    chk("restart_nowrite", 32'(got.size()), 0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'h83, 1'b0);
    k = 0;
    while (active !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk("restart_nwrites", 32'(got.size()), 1);
    if (got.size() > 0) chk("restart_word", 32'(got[0]), 32'({32'd0, 12'h3AA}));
    chk("restart_active", 32'(active), 1);
    chk("restart_count", line_count, 1);

    reset_reset_n = 1'b0;
    tick();
    check_all_zero("rst_run");
    reset_reset_n = 1'b1;
    got.delete();
    host_valid = 1'b1;
    host_byte  = 8'h12;
    repeat (5) tick();
    chk("idle_ready", 32'(host_ready), 0);
    chk("idle_nowrite", 32'(got.size()), 0);
    chk("idle_loading", 32'(loading), 0);
    host_valid = 1'b0;

    rand_words(3);
    load_and_check("reload", 1'b1);
    rand_words(1);
    load_and_check("rerun", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
